// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader. Receives a byte stream, assembles it
// little-endian into 32-bit words and writes them to consecutive
// instruction-memory addresses starting at 0. The core's fetch stage is held
// stalled until the load finishes.
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, a running XOR of all payload bytes is
//                       kept. One trailing checksum byte is accepted after the
//                       last word, and err_o flags a mismatch. When undefined,
//                       the CHECK state and the XOR logic are absent and err_o
//                       is tied low.
//
// Parameters:
//   ADDR_WIDTH  word-address width (memory depth 2**ADDR_WIDTH words)
//   DATA_WIDTH  instruction word width (32)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset; aborts any load in progress
//   start_i       begin a load (only looked at in IDLE and DONE)
//   word_count_i  number of words to load; saturated to 2**ADDR_WIDTH
//   byte_valid_i  source presents a byte
//   byte_data_i   byte payload
//   byte_ready_o  loader accepts a byte this cycle
//   imem_we_o     instruction-memory write strobe (one cycle per word)
//   imem_addr_o   word address of the write
//   imem_wdata_o  word to write
//   core_hold_o   high = fetch stage stalled
//   busy_o        load in progress
//   done_o        last load finished
//   err_o         checksum mismatch
//
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both high. The source keeps byte_valid_i/byte_data_i
// steady until that edge; byte_ready_o does not depend on byte_valid_i.
//
// The current FSM state is held in the `state` signal (type state_t) for
// checkers to observe.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] imem_wdata_o,
  output logic                  core_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE
  } state_t;
`endif

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           word_count;
  logic [CW-1:0]           word_idx;
  logic [1:0]              byte_idx;
  logic [23:0]             word_buf;   // bytes 0..2 of the word being built
  logic                    byte_ready_q;
  logic                    imem_we_q;
  logic [ADDR_WIDTH-1:0]   imem_addr_q;
  logic [DATA_WIDTH-1:0]   imem_wdata_q;
  logic                    core_hold_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    byte_xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              xor_q;
  logic                    err_q;
`endif

  assign byte_xfer = byte_valid_i && byte_ready_q;

  // Next-state decode only; all state and outputs live in the always_ff.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // A zero-length load finishes at once; no checksum byte expected.
          state_nxt = (word_count_i == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (byte_xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (word_idx + 1'b1 == word_count) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_xfer) state_nxt = S_DONE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      word_count   <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            word_count <= (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
            word_idx   <= '0;
            byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        S_RECV: begin
          if (byte_xfer) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_q    <= xor_q ^ byte_data_i;
`endif
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_data_i;
              2'd1: word_buf[15:8]  <= byte_data_i;
              2'd2: word_buf[23:16] <= byte_data_i;
              default: begin
                // Fourth byte: the word is complete, present it for WRITE.
                imem_wdata_q <= DATA_WIDTH'({byte_data_i, word_buf});
                imem_addr_q  <= word_idx[ADDR_WIDTH-1:0];
              end
            endcase
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_xfer) err_q <= (byte_data_i != xor_q);
        end
`endif
        default: ;
      endcase

      // Outputs are registered as a decode of the state being entered.
      state        <= state_nxt;
`ifdef LOADER_CHECKSUM_EN
      byte_ready_q <= (state_nxt == S_RECV) || (state_nxt == S_CHECK);
      busy_q       <= (state_nxt == S_RECV) || (state_nxt == S_WRITE) ||
                      (state_nxt == S_CHECK);
`else
      byte_ready_q <= (state_nxt == S_RECV);
      busy_q       <= (state_nxt == S_RECV) || (state_nxt == S_WRITE);
`endif
      imem_we_q    <= (state_nxt == S_WRITE);
      done_q       <= (state_nxt == S_DONE);
      core_hold_q  <= (state_nxt != S_DONE);
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign core_hold_o  = core_hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader (ADDR_WIDTH=8, DATA_WIDTH=32). Inputs change
// 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Every memory write is checked against exp_q ({addr, data}) as it happens.
// Builds with or without LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int EW = AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW:0]   word_count_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_wdata_o;
  logic          core_hold_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int            total = 0;
  int            bad   = 0;
  int            we_cycles = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    tb_xor;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_hold_o  (core_hold_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // ---- clock / watchdog ----------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1, "watchdog expired");
  end

  // ---- scoreboard: every write strobe must match the next expected write ---
  always @(negedge clk) begin
    if (imem_we_o === 1'b1) begin
      logic [EW-1:0] e;
      we_cycles++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, expected no write",
                 imem_addr_o, imem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr_o, imem_wdata_o} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   imem_addr_o, imem_wdata_o, e[EW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---- driver tasks --------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    start_i      = 1'b0;
    word_count_i = '0;
    byte_valid_i = 1'b0;
    byte_data_i  = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_load(input logic [AW:0] n);
    start_i      = 1'b1;
    word_count_i = n;
    tb_xor       = '0;
    tick();
    start_i      = 1'b0;
  endtask

  // Presents one byte after `gap` idle cycles; ok=0 if never accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) tick();
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready_o === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    byte_valid_i = 1'b0;
    if (ok) tb_xor = tb_xor ^ b;
  endtask

  // Sends the trailing checksum byte when the loader expects one.
  task automatic send_checksum(input logic [7:0] c, output bit ok);
`ifdef LOADER_CHECKSUM_EN
    send_byte(c, 0, ok);
`else
    ok = (c == c);
`endif
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  // Sends a list of bytes with a fixed gap, counting any handshake timeout.
  task automatic send_stream(input logic [7:0] bytes[], input int gap, output int lost);
    bit ok;
    lost = 0;
    foreach (bytes[i]) begin
      send_byte(bytes[i], gap, ok);
      if (!ok) lost++;
    end
  endtask

  // ---- tests ---------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({byte_ready_o, imem_we_o, busy_o, done_o, err_o, core_hold_o} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_flags: got rdy/we/busy/done/err/hold=%b, expected 000001",
               {byte_ready_o, imem_we_o, busy_o, done_o, err_o, core_hold_o});
    end
    total++;
    if ({imem_addr_o, imem_wdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got addr=%0h data=%08h, expected 0/0", imem_addr_o, imem_wdata_o);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({core_hold_o, busy_o, done_o} !== 3'b100) begin
        bad++;
        $display("FAIL idle_cycle%0d: got hold/busy/done=%b, expected 100",
                 c, {core_hold_o, busy_o, done_o});
      end
      tick();
    end
    total++;
    if (we_cycles !== 0) begin
      bad++;
      $display("FAIL idle_no_write: got %0d strobes, expected 0", we_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int  w0, lost;
    bit  ok;
    w0 = we_cycles;
    exp_q.push_back({8'h00, 32'h12345678});
    exp_q.push_back({8'h01, 32'hDEADBEEF});
    start_load(2);
    send_stream(bytes, 0, lost);
    send_checksum(tb_xor, ok);
    if (!ok) lost++;
    wait_done(ok);
    total++;
    if (!ok || lost != 0) begin
      bad++;
      $display("FAIL b2b_complete: done=%0b lost_bytes=%0d, expected done=1 lost=0", ok, lost);
    end
    total++;
    if (exp_q.size() != 0 || we_cycles - w0 != 2) begin
      bad++;
      $display("FAIL b2b_writes: got %0d strobes (%0d pending), expected 2",
               we_cycles - w0, exp_q.size());
    end
    @(negedge clk);
    total++;
    if ({done_o, core_hold_o, busy_o, err_o, byte_ready_o} !== 5'b10000) begin
      bad++;
      $display("FAIL b2b_final: got done/hold/busy/err/rdy=%b, expected 10000",
               {done_o, core_hold_o, busy_o, err_o, byte_ready_o});
    end
    tick();
  endtask

  task automatic test_gaps();
    logic [7:0] bytes[] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int  w0, lost;
    bit  ok;
    w0 = we_cycles;
    exp_q.push_back({8'h00, 32'h04030201});
    start_load(1);
    send_stream(bytes, 3, lost);
    send_checksum(tb_xor, ok);
    if (!ok) lost++;
    wait_done(ok);
    repeat (3) tick();
    total++;
    if (!ok || lost != 0 || exp_q.size() != 0 || we_cycles - w0 != 1) begin
      bad++;
      $display("FAIL gap_load: done=%0b lost=%0d strobes=%0d pending=%0d, expected 1/0/1/0",
               ok, lost, we_cycles - w0, exp_q.size());
    end
  endtask

  task automatic test_checksum();
    logic [7:0] bytes[] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int  lost;
    bit  ok, ok2;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sums[2] = '{8'h04, 8'h05};
    logic       exp_err[2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({8'h00, 32'h04030201});
      start_load(1);
      send_stream(bytes, 0, lost);
      send_byte(sums[k], 0, ok);
      wait_done(ok2);
      @(negedge clk);
      total++;
      if (!ok || !ok2 || lost != 0 || err_o !== exp_err[k] || done_o !== 1'b1) begin
        bad++;
        $display("FAIL checksum_%02h: got err=%b done=%b (ok=%0b/%0b lost=%0d), expected err=%b done=1",
                 sums[k], err_o, done_o, ok, ok2, lost, exp_err[k]);
      end
      tick();
    end
`else
    exp_q.push_back({8'h00, 32'h04030201});
    start_load(1);
    send_stream(bytes, 0, lost);
    wait_done(ok);
    @(negedge clk);
    total++;
    if (!ok || lost != 0 || err_o !== 1'b0 || byte_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL no_checksum: got err=%b rdy=%b done_seen=%0b lost=%0d, expected err=0 rdy=0",
               err_o, byte_ready_o, ok, lost);
    end
    tick();
`endif
  endtask

  task automatic test_reset_abort();
    logic [7:0] part[]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] fresh[] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int  w0, lost;
    bit  ok;
    w0 = we_cycles;
    exp_q.push_back({8'h00, 32'h44332211});
    start_load(3);
    send_stream(part, 0, lost);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({core_hold_o, busy_o, done_o, byte_ready_o, imem_we_o} !== 5'b10000) begin
      bad++;
      $display("FAIL abort_state: got hold/busy/done/rdy/we=%b, expected 10000",
               {core_hold_o, busy_o, done_o, byte_ready_o, imem_we_o});
    end
    repeat (3) tick();
    total++;
    if (lost != 0 || exp_q.size() != 0 || we_cycles - w0 != 1) begin
      bad++;
      $display("FAIL abort_writes: got %0d strobes (%0d pending, lost=%0d), expected 1",
               we_cycles - w0, exp_q.size(), lost);
    end
    exp_q.push_back({8'h00, 32'hA4A3A2A1});
    start_load(1);
    send_stream(fresh, 0, lost);
    send_checksum(tb_xor, ok);
    if (!ok) lost++;
    wait_done(ok);
    total++;
    if (!ok || lost != 0 || exp_q.size() != 0 || we_cycles - w0 != 2) begin
      bad++;
      $display("FAIL reload_after_abort: done=%0b lost=%0d strobes=%0d, expected 1/0/2",
               ok, lost, we_cycles - w0);
    end
  endtask

  task automatic test_zero_count();
    int w0;
    do_reset();
    w0 = we_cycles;
    start_load(0);
    @(negedge clk);
    total++;
    if ({done_o, busy_o, core_hold_o, byte_ready_o} !== 4'b1000) begin
      bad++;
      $display("FAIL zero_count: got done/busy/hold/rdy=%b, expected 1000",
               {done_o, busy_o, core_hold_o, byte_ready_o});
    end
    repeat (4) tick();
    total++;
    if (we_cycles != w0 || done_o !== 1'b1) begin
      bad++;
      $display("FAIL zero_no_write: got %0d strobes done=%b, expected 0 strobes done=1",
               we_cycles - w0, done_o);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] head[] = '{8'h01, 8'h23};
    logic [7:0] tail[] = '{8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    int  w0, lost, lost2;
    bit  ok;
    w0 = we_cycles;
    exp_q.push_back({8'h00, 32'h67452301});
    exp_q.push_back({8'h01, 32'hEFCDAB89});
    start_load(2);
    send_stream(head, 0, lost);
    start_i      = 1'b1;
    word_count_i = 9'd1;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_recv: got busy=%b, expected 1", busy_o);
    end
    tick();
    start_i = 1'b0;
    send_stream(tail, 0, lost2);
    send_checksum(tb_xor, ok);
    if (!ok) lost2++;
    wait_done(ok);
    total++;
    if (!ok || lost + lost2 != 0 || exp_q.size() != 0 || we_cycles - w0 != 2) begin
      bad++;
      $display("FAIL start_ignored: done=%0b lost=%0d strobes=%0d pending=%0d, expected 1/0/2/0",
               ok, lost + lost2, we_cycles - w0, exp_q.size());
    end
  endtask

  task automatic test_saturate();
    int         w0, lost;
    bit         ok;
    logic [7:0] b;
    w0   = we_cycles;
    lost = 0;
    for (int w = 0; w < 256; w++) begin
      logic [7:0] a0, a1, a2, a3, ad;
      a0 = 8'(4 * w);
      a1 = 8'(4 * w + 1);
      a2 = 8'(4 * w + 2);
      a3 = 8'(4 * w + 3);
      ad = 8'(w);
      exp_q.push_back({ad, a3, a2, a1, a0});
    end
    start_load(9'h1FF);
    for (int k = 0; k < 1024; k++) begin
      b = 8'(k);
      send_byte(b, 0, ok);
      if (!ok) lost++;
      if (lost > 2) break;
    end
    send_checksum(tb_xor, ok);
    if (!ok) lost++;
    wait_done(ok);
    total++;
    if (!ok || lost != 0 || exp_q.size() != 0 || we_cycles - w0 != 256) begin
      bad++;
      $display("FAIL saturate: done=%0b lost=%0d strobes=%0d pending=%0d, expected 1/0/256/0",
               ok, lost, we_cycles - w0, exp_q.size());
    end
    @(negedge clk);
    total++;
    if (byte_ready_o !== 1'b0 || core_hold_o !== 1'b0) begin
      bad++;
      $display("FAIL saturate_final: got rdy=%b hold=%b, expected 0/0", byte_ready_o, core_hold_o);
    end
    tick();
  endtask

  // ---- sequence / report ---------------------------------------------------
  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_checksum();
    test_reset_abort();
    test_zero_count();
    test_start_ignored();
    test_saturate();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
